// File: rtl/register_file_sb_if.sv
// ============================================================================
// register_file_sb_if : issue/writeback bus of the scoreboarded register file
// Rev 1.0
// ============================================================================
`default_nettype none

interface register_file_sb_if #(
  parameter int BIT_NUMBER  = 64,
  parameter int ADDR_NUMBER = 5
);
  logic                   enable;
  logic                   rd_en;
  logic [ADDR_NUMBER-1:0] src_addr_1;
  logic [ADDR_NUMBER-1:0] src_addr_2;
  logic [BIT_NUMBER-1:0]  data_out_1;
  logic [BIT_NUMBER-1:0]  data_out_2;
  logic                   src_ready_1;
  logic                   src_ready_2;
  logic                   rsv_en;
  logic [ADDR_NUMBER-1:0] rsv_addr;
  logic                   rsv_grant;
  logic                   write_enable;
  logic [ADDR_NUMBER-1:0] dest_addr;
  logic [BIT_NUMBER-1:0]  write_data;
  logic [ADDR_NUMBER:0]   pending_count;
  logic                   write_err;

  modport master (
    output enable, rd_en, src_addr_1, src_addr_2, rsv_en, rsv_addr,
           write_enable, dest_addr, write_data,
    input  data_out_1, data_out_2, src_ready_1, src_ready_2, rsv_grant,
           pending_count, write_err
  );

  modport slave (
    input  enable, rd_en, src_addr_1, src_addr_2, rsv_en, rsv_addr,
           write_enable, dest_addr, write_data,
    output data_out_1, data_out_2, src_ready_1, src_ready_2, rsv_grant,
           pending_count, write_err
  );
endinterface

`default_nettype wire

// File: rtl/register_file_sb.sv
// ============================================================================
// register_file_sb : 2R/1W register file with pending-bit scoreboard and bypass
// Rev 1.0
// ============================================================================
`default_nettype none

module register_file_sb #(
  parameter int BIT_NUMBER      = 64,
  parameter int ADDR_NUMBER     = 5,
  parameter int REGISTER_NUMBER = 16,
  parameter int ZERO_REG        = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  register_file_sb_if.slave   bus
);

  localparam int CW = ADDR_NUMBER + 1;
  typedef logic [ADDR_NUMBER-1:0] addr_t;

  function automatic logic in_range(input addr_t a);
    return {1'b0, a} < CW'(REGISTER_NUMBER);
  endfunction

  function automatic logic is_zero(input addr_t a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic [BIT_NUMBER-1:0]      regs_q [REGISTER_NUMBER];
  logic [REGISTER_NUMBER-1:0] pend_q, pend_d;
  logic [REGISTER_NUMBER-1:0] wr_sel, rsv_sel, wr_hit, rsv_hit;
  logic [CW-1:0]              count_q, count_d;
  logic                       err_q;
  logic [BIT_NUMBER-1:0]      data1_q, data2_q, data1_d, data2_d;
  logic                       rdy1_q, rdy2_q, pend1, pend2;
  logic                       wr_fire, rsv_valid, rsv_pend, dest_pend, same_reg;
  logic                       grant, rsv_set, inc, dec;

  assign wr_fire   = bus.enable & bus.write_enable & in_range(bus.dest_addr) & ~is_zero(bus.dest_addr);
  assign rsv_valid = in_range(bus.rsv_addr) & ~is_zero(bus.rsv_addr);
  assign same_reg  = bus.write_enable & (bus.dest_addr == bus.rsv_addr);
  // Register 0 always grants so the issue stage never stalls on it.
  assign grant     = bus.enable & bus.rsv_en &
                     (is_zero(bus.rsv_addr) | (rsv_valid & (~rsv_pend | same_reg)));
  assign rsv_set   = grant & rsv_valid;

  always_comb begin
    wr_sel  = '0;
    rsv_sel = '0;
    for (int i = 0; i < REGISTER_NUMBER; i++) begin
      wr_sel[i]  = (bus.dest_addr == addr_t'(i));
      rsv_sel[i] = (bus.rsv_addr == addr_t'(i));
    end
  end

  assign wr_hit    = wr_sel & {REGISTER_NUMBER{wr_fire}};
  assign rsv_hit   = rsv_sel & {REGISTER_NUMBER{rsv_set}};
  assign rsv_pend  = |(pend_q & rsv_sel);
  assign dest_pend = |(pend_q & wr_sel);
  assign pend_d    = (pend_q & ~wr_hit) | rsv_hit;
  // A clear-and-re-reserve of one register is net zero for the counter.
  assign inc       = rsv_set & ~|(pend_q & ~wr_hit & rsv_sel);
  assign dec       = wr_fire & dest_pend;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q < CW'(REGISTER_NUMBER)))
      count_d = count_q + 1'b1;
    else if (dec && !inc && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  always_comb begin
    data1_d = '0;
    data2_d = '0;
    pend1   = 1'b0;
    pend2   = 1'b0;
    for (int i = 0; i < REGISTER_NUMBER; i++) begin
      if (bus.src_addr_1 == addr_t'(i)) begin
        data1_d = regs_q[i];
        pend1   = pend_d[i];
      end
      if (bus.src_addr_2 == addr_t'(i)) begin
        data2_d = regs_q[i];
        pend2   = pend_d[i];
      end
    end
    if (wr_fire && (bus.dest_addr == bus.src_addr_1)) data1_d = bus.write_data;
    if (wr_fire && (bus.dest_addr == bus.src_addr_2)) data2_d = bus.write_data;
    if (!in_range(bus.src_addr_1) || is_zero(bus.src_addr_1)) begin
      data1_d = '0;
      pend1   = 1'b0;
    end
    if (!in_range(bus.src_addr_2) || is_zero(bus.src_addr_2)) begin
      data2_d = '0;
      pend2   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < REGISTER_NUMBER; i++) regs_q[i] <= '0;
      pend_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
      rdy1_q  <= 1'b0;
      rdy2_q  <= 1'b0;
    end else if (bus.enable) begin
      for (int i = 0; i < REGISTER_NUMBER; i++)
        if (wr_hit[i]) regs_q[i] <= bus.write_data;
      pend_q  <= pend_d;
      count_q <= count_d;
      if (wr_fire && !dest_pend) err_q <= 1'b1;
      if (bus.rd_en) begin
        data1_q <= data1_d;
        data2_q <= data2_d;
        rdy1_q  <= ~pend1;
        rdy2_q  <= ~pend2;
      end
    end
  end

  assign bus.data_out_1    = data1_q;
  assign bus.data_out_2    = data2_q;
  assign bus.src_ready_1   = rdy1_q;
  assign bus.src_ready_2   = rdy2_q;
  assign bus.rsv_grant     = grant;
  assign bus.pending_count = count_q;
  assign bus.write_err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_register_file_sb.sv
// ============================================================================
// tb_register_file_sb : scoreboard-driven self-checking bench for register_file_sb
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_register_file_sb;

  typedef struct packed {
    logic [63:0] d1;
    logic        r1;
    logic [63:0] d2;
    logic        r2;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  rd_t  exp_q[$];
  rd_t  got, e;

  register_file_sb_if #(.BIT_NUMBER(64), .ADDR_NUMBER(5)) bus ();

  register_file_sb #(
    .BIT_NUMBER(64), .ADDR_NUMBER(5), .REGISTER_NUMBER(16), .ZERO_REG(1)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_en        = 1'b0;
    bus.rsv_en       = 1'b0;
    bus.write_enable = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input rd_t exp);
    bus.rd_en      = 1'b1;
    bus.src_addr_1 = a1;
    bus.src_addr_2 = a2;
    exp_q.push_back(exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    bus.write_enable = 1'b1;
    bus.dest_addr    = a;
    bus.write_data   = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
  endtask

  task automatic test_reset();
    bus.enable = 1'b1;
    rst = 1'b1;
    wr(5'd1, 64'hAAAA);
    rsv(5'd2);
    bus.rd_en = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    checks++;
    if (got !== rd_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    checks++;
    if (bus.pending_count !== 6'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", bus.pending_count);
    end
    checks++;
    if (bus.write_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", bus.write_err);
    end
    rd(5'd3, 5'd5, '{64'h0, 1'b1, 64'h0, 1'b1});
    tick();
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_read: got %h expected %h", got, e);
    end
  endtask

  task automatic test_reserve();
    rsv(5'd4);
    #1;
    checks++;
    if (bus.rsv_grant !== 1'b1) begin
      errors++;
      $display("FAIL rsv_grant_first: got %b expected 1", bus.rsv_grant);
    end
    tick();
    checks++;
    if (bus.pending_count !== 6'd1) begin
      errors++;
      $display("FAIL rsv_count_up: got %0d expected 1", bus.pending_count);
    end
    #1;
    checks++;
    if (bus.rsv_grant !== 1'b0) begin
      errors++;
      $display("FAIL rsv_grant_second: got %b expected 0", bus.rsv_grant);
    end
    tick();
    idle();
    checks++;
    if (bus.pending_count !== 6'd1) begin
      errors++;
      $display("FAIL rsv_count_hold: got %0d expected 1", bus.pending_count);
    end
    rd(5'd4, 5'd3, '{64'h0, 1'b0, 64'h0, 1'b1});
    tick();
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL rsv_read_pending: got %h expected %h", got, e);
    end
    wr(5'd4, 64'hDEAD_BEEF);
    tick();
    idle();
    checks++;
    if (bus.pending_count !== 6'd0 || bus.write_err !== 1'b0) begin
      errors++;
      $display("FAIL rsv_writeback: got count=%0d err=%b expected count=0 err=0",
               bus.pending_count, bus.write_err);
    end
    rd(5'd4, 5'd4, '{64'hDEAD_BEEF, 1'b1, 64'hDEAD_BEEF, 1'b1});
    tick();
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL rsv_read_written: got %h expected %h", got, e);
    end
  endtask

  task automatic test_bypass();
    rsv(5'd7);
    tick();
    idle();
    wr(5'd7, 64'h1234);
    rd(5'd7, 5'd4, '{64'h1234, 1'b1, 64'hDEAD_BEEF, 1'b1});
    tick();
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL bypass_read: got %h expected %h", got, e);
    end
    checks++;
    if (bus.pending_count !== 6'd0) begin
      errors++;
      $display("FAIL bypass_count: got %0d expected 0", bus.pending_count);
    end
    rsv(5'd7);
    tick();
    idle();
    wr(5'd7, 64'h5678);
    rsv(5'd7);
    rd(5'd7, 5'd7, '{64'h5678, 1'b0, 64'h5678, 1'b0});
    #1;
    checks++;
    if (bus.rsv_grant !== 1'b1) begin
      errors++;
      $display("FAIL clr_rsv_grant: got %b expected 1", bus.rsv_grant);
    end
    tick();
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL clr_rsv_read: got %h expected %h", got, e);
    end
    checks++;
    if (bus.pending_count !== 6'd1 || bus.write_err !== 1'b0) begin
      errors++;
      $display("FAIL clr_rsv_count: got count=%0d err=%b expected count=1 err=0",
               bus.pending_count, bus.write_err);
    end
  endtask

  task automatic test_back_to_back();
    wr(5'd7, 64'h77);
    rsv(5'd8);
    #1;
    checks++;
    if (bus.rsv_grant !== 1'b1) begin
      errors++;
      $display("FAIL b2b_grant: got %b expected 1", bus.rsv_grant);
    end
    tick();
    idle();
    checks++;
    if (bus.pending_count !== 6'd1) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 1", bus.pending_count);
    end
    rd(5'd7, 5'd8, '{64'h77, 1'b1, 64'h0, 1'b0});
    tick();
    wr(5'd8, 64'h88);
    rd(5'd8, 5'd7, '{64'h88, 1'b1, 64'h77, 1'b1});
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL b2b_read_a: got %h expected %h", got, e);
    end
    tick();
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL b2b_read_b: got %h expected %h", got, e);
    end
    checks++;
    if (bus.pending_count !== 6'd0) begin
      errors++;
      $display("FAIL b2b_count_end: got %0d expected 0", bus.pending_count);
    end
  endtask

  task automatic test_zero_reg();
    wr(5'd0, 64'hFF);
    rsv(5'd0);
    #1;
    checks++;
    if (bus.rsv_grant !== 1'b1) begin
      errors++;
      $display("FAIL zero_grant: got %b expected 1", bus.rsv_grant);
    end
    tick();
    idle();
    wr(5'd20, 64'hAA);
    rsv(5'd20);
    rd(5'd0, 5'd20, '{64'h0, 1'b1, 64'h0, 1'b1});
    #1;
    checks++;
    if (bus.rsv_grant !== 1'b0) begin
      errors++;
      $display("FAIL range_grant: got %b expected 0", bus.rsv_grant);
    end
    tick();
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL zero_range_read: got %h expected %h", got, e);
    end
    checks++;
    if (bus.pending_count !== 6'd0 || bus.write_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_range_state: got count=%0d err=%b expected count=0 err=0",
               bus.pending_count, bus.write_err);
    end
  endtask

  task automatic test_write_err();
    wr(5'd2, 64'h22);
    tick();
    idle();
    checks++;
    if (bus.write_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b expected 1", bus.write_err);
    end
    tick();
    tick();
    checks++;
    if (bus.write_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", bus.write_err);
    end
    rsv(5'd1);
    tick();
    rsv(5'd3);
    tick();
    rsv(5'd5);
    tick();
    idle();
    checks++;
    if (bus.pending_count !== 6'd3) begin
      errors++;
      $display("FAIL err_count3: got %0d expected 3", bus.pending_count);
    end
    rd(5'd1, 5'd3, '{64'h0, 1'b0, 64'h0, 1'b0});
    tick();
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL err_pending_read: got %h expected %h", got, e);
    end
    rst = 1'b1;
    wr(5'd1, 64'h11);
    rsv(5'd6);
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (bus.pending_count !== 6'd0 || bus.write_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got count=%0d err=%b expected count=0 err=0",
               bus.pending_count, bus.write_err);
    end
    rd(5'd1, 5'd3, '{64'h0, 1'b1, 64'h0, 1'b1});
    tick();
    rd(5'd5, 5'd2, '{64'h0, 1'b1, 64'h0, 1'b1});
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_read_a: got %h expected %h", got, e);
    end
    tick();
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_read_b: got %h expected %h", got, e);
    end
  endtask

  task automatic test_enable();
    rsv(5'd9);
    tick();
    idle();
    rd(5'd9, 5'd10, '{64'h0, 1'b0, 64'h0, 1'b1});
    tick();
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL en_setup: got %h expected %h", got, e);
    end
    bus.enable = 1'b0;
    wr(5'd9, 64'h99);
    rsv(5'd10);
    bus.rd_en      = 1'b1;
    bus.src_addr_1 = 5'd2;
    bus.src_addr_2 = 5'd10;
    #1;
    checks++;
    if (bus.rsv_grant !== 1'b0) begin
      errors++;
      $display("FAIL en_grant: got %b expected 0", bus.rsv_grant);
    end
    tick();
    tick();
    tick();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    checks++;
    if (got !== e || bus.pending_count !== 6'd1 || bus.write_err !== 1'b0) begin
      errors++;
      $display("FAIL en_frozen: got %h count=%0d err=%b expected %h count=1 err=0",
               got, bus.pending_count, bus.write_err, e);
    end
    idle();
    bus.enable = 1'b1;
    rd(5'd9, 5'd10, '{64'h0, 1'b0, 64'h0, 1'b1});
    tick();
    wr(5'd9, 64'h99);
    rd(5'd9, 5'd10, '{64'h99, 1'b1, 64'h0, 1'b1});
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL en_resume_a: got %h expected %h", got, e);
    end
    tick();
    idle();
    got = '{bus.data_out_1, bus.src_ready_1, bus.data_out_2, bus.src_ready_2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL en_resume_b: got %h expected %h", got, e);
    end
    checks++;
    if (bus.pending_count !== 6'd0 || bus.write_err !== 1'b0) begin
      errors++;
      $display("FAIL en_resume_state: got count=%0d err=%b expected count=0 err=0",
               bus.pending_count, bus.write_err);
    end
  endtask

  initial begin
    bus.enable       = 1'b1;
    bus.rd_en        = 1'b0;
    bus.src_addr_1   = '0;
    bus.src_addr_2   = '0;
    bus.rsv_en       = 1'b0;
    bus.rsv_addr     = '0;
    bus.write_enable = 1'b0;
    bus.dest_addr    = '0;
    bus.write_data   = '0;
    #2;
    test_reset();
    test_reserve();
    test_bypass();
    test_back_to_back();
    test_zero_reg();
    test_write_err();
    test_enable();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
